hwpe_ctrl_uloop_seq: RTL and testbench
======================================

# hwpe_ctrl_uloop_seq

Upstream sequencer for the HWPE microcode loop engine (uloop, non-shadowed configuration). On a job start it clears the uloop and drives its enable. Each time the uloop reports a valid iteration, it samples the updated offset registers and computes one absolute base address per streamer (`base + offset`). It buffers these descriptors in a small FIFO toward the streamers and signals job completion once the final descriptor has been consumed.

## Interface
- `NB_STREAM`, default 4: number of streamer base addresses per descriptor; must be ≤ `NB_REG`.
- `NB_REG`, default 4: number of uloop offset registers.
- `NB_LOOPS`, default 6: number of uloop loop levels.
- `REG_WIDTH`, default 32: width of a uloop offset register.
- `ADDR_WIDTH`, default 32: width of a base/output address; must be ≥ `REG_WIDTH`.
- `FIFO_DEPTH`, default 2: descriptor FIFO entries; power of two, ≥ 2.
- `clk_i` — in — 1 — clock.
- `rst_ni` — in — 1 — reset, asynchronous, active-low.
- `clear_i` — in — 1 — synchronous soft clear; same effect as reset.
- `start_i` — in — 1 — job start pulse.
- `base_i` — in — `NB_STREAM`×`ADDR_WIDTH` — per-streamer job base addresses.
- `busy_o` — out — 1 — job in progress.
- `done_o` — out — 1 — one-cycle job-complete pulse.
- `uloop_clear_o` — out — 1 — clear pulse to the uloop.
- `uloop_enable_o` — out — 1 — uloop step enable.
- `uloop_valid_i` — in — 1 — uloop flags valid.
- `uloop_done_i` — in — 1 — uloop done flag.
- `uloop_loop_i` — in — `$clog2(NB_LOOPS)` — loop level that produced the iteration.
- `uloop_offs_i` — in — `NB_REG`×`REG_WIDTH` — uloop offset registers.
- `desc_valid_o` — out — 1 — descriptor valid.
- `desc_ready_i` — in — 1 — descriptor accepted by the consumer.
- `desc_addr_o` — out — `NB_STREAM`×`ADDR_WIDTH` — per-streamer absolute addresses.
- `desc_loop_o` — out — `$clog2(NB_LOOPS)` — loop level of the descriptor.
- `desc_last_o` — out — 1 — final descriptor of the job.

## Operation
- FSM states: `IDLE`, `INIT`, `STEP`, `CHECK`, `DRAIN`.
- `IDLE`:
  - `start_i` samples `base_i` into internal registers and moves to `INIT`.
  - `start_i` in any other state is ignored.
- `INIT`: `uloop_clear_o`=1 for exactly one cycle, then `STEP`.
- `STEP`:
  - `uloop_enable_o`=1.
  - When `uloop_valid_i`=1, push one FIFO entry: `addr[k] = base[k] + zero-extend(uloop_offs_i[k])` modulo 2^`ADDR_WIDTH`; `loop = uloop_loop_i`; `last = uloop_done_i`. Then go to `CHECK`.
- `CHECK`:
  - `uloop_enable_o`=0.
  - If the last pushed entry had `last`=1, go to `DRAIN`.
  - Else if the FIFO is not full, go to `STEP`.
  - Else wait in `CHECK`.
- `DRAIN`: when the FIFO is empty, pulse `done_o` and go to `IDLE`.
- `STEP` is entered only with at least one free FIFO slot, so a push never overflows.
- `busy_o`=1 in every state except `IDLE`.
- FIFO behaviour:
  - Standard valid/ready. A pop occurs when `desc_valid_o & desc_ready_i`.
  - A simultaneous push and pop when full is not possible (`STEP` never entered while full). When the FIFO is non-full, simultaneous push and pop keep the occupancy unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - `desc_*_o` reflect the head entry; they are 0 when the FIFO is empty.
- `clear_i` (and reset mid-job):
  - FSM returns to `IDLE`, the FIFO is emptied, and stored bases are cleared.
  - No `done_o` pulse is emitted.
  - `uloop_clear_o` is not driven by `clear_i`.

## Timing
- Reset values: `busy_o`, `done_o`, `uloop_clear_o`, `uloop_enable_o`, `desc_valid_o`, `desc_last_o` = 0; `desc_addr_o`, `desc_loop_o` = 0.
- Cycle map:
  - `start_i` at cycle 0 → `INIT` at cycle 1 (`uloop_clear_o`=1, `busy_o`=1).
  - `STEP` from cycle 2 (`uloop_enable_o`=1).
- Valid sampled at cycle n:
  - Entry is visible on `desc_*_o` at cycle n+1 (registered FIFO, zero bypass).
  - `uloop_enable_o`=0 at cycle n+1.
  - `uloop_enable_o` re-asserted at cycle n+2 if not full.
- Last descriptor popped at cycle m → `done_o` at cycle m+1, `busy_o`=0 at cycle m+2, `IDLE` accepts `start_i` at cycle m+2.
- `desc_valid_o` never drops without a pop; `desc_*_o` stay stable while stalled.
- Address arithmetic is purely combinational before the FIFO write; no extra latency.

## Test plan
- Single-iteration job:
  - Stimulus: `base_i[0]`=0x1000, `uloop_offs_i[0]`=0x40, valid+done at first `STEP` cycle.
  - Response: one descriptor with addr0=0x1040, `desc_last_o`=1; `done_o` one cycle after the pop; `uloop_clear_o` exactly one pulse.
- Back-pressure:
  - Stimulus: `desc_ready_i`=0, `FIFO_DEPTH`=2, valid on every `STEP` cycle.
  - Response: exactly 2 pushes, then `uloop_enable_o` held 0 in `CHECK`. One pop re-enables `STEP` within 2 cycles; no descriptor lost or duplicated.
- Wrap-around:
  - Stimulus: `base_i[1]`=0xFFFF_FFF0, offset 0x20.
  - Response: addr1=0x0000_0010.
  - Also run 10 iterations through the 2-entry FIFO with random ready; descriptors must come out in push order.
- Loop tagging:
  - Stimulus: `uloop_loop_i` sequence 0,0,1,2 with done on the last.
  - Response: `desc_loop_o` = 0,0,1,2; only the 4th descriptor has `desc_last_o`=1.
- Clear mid-job:
  - Stimulus: `clear_i` while the FIFO holds 1 entry in `CHECK`.
  - Response: next cycle `busy_o`=0, `desc_valid_o`=0, no `done_o`. A new `start_i` then runs normally with fresh bases.
- Start while busy: `start_i` asserted in `STEP` is ignored; `base_i` changes do not alter the bases in use.

Source files
------------

// File: rtl/hwpe_ctrl_uloop_seq.sv
// hwpe_ctrl_uloop_seq: drives the uloop through a job and queues one base+offset
// descriptor per uloop iteration in a small FIFO toward the streamers.
module hwpe_ctrl_uloop_seq #(
    parameter int unsigned NB_STREAM  = 4,
    parameter int unsigned NB_REG     = 4,
    parameter int unsigned NB_LOOPS   = 6,
    parameter int unsigned REG_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              clear_i,
    input  logic                              start_i,
    input  logic [NB_STREAM*ADDR_WIDTH-1:0]   base_i,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              uloop_clear_o,
    output logic                              uloop_enable_o,
    input  logic                              uloop_valid_i,
    input  logic                              uloop_done_i,
    input  logic [$clog2(NB_LOOPS)-1:0]       uloop_loop_i,
    input  logic [NB_REG*REG_WIDTH-1:0]       uloop_offs_i,
    output logic                              desc_valid_o,
    input  logic                              desc_ready_i,
    output logic [NB_STREAM*ADDR_WIDTH-1:0]   desc_addr_o,
    output logic [$clog2(NB_LOOPS)-1:0]       desc_loop_o,
    output logic                              desc_last_o
);
    localparam int unsigned LW = $clog2(NB_LOOPS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned DW = NB_STREAM * ADDR_WIDTH;

    typedef enum logic [2:0] {IDLE, INIT, STEP, CHECK, DRAIN} state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   base_q;
    logic [DW-1:0]   addr_mem_q [FIFO_DEPTH];
    logic [LW-1:0]   loop_mem_q [FIFO_DEPTH];
    logic            last_mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wptr_q, rptr_q;
    logic [CW-1:0]   cnt_q;
    logic            last_q;
    logic [DW-1:0]   push_addr;
    logic            push, pop, full, empty;

    for (genvar k = 0; k < NB_STREAM; k++) begin : g_addr
        assign push_addr[k*ADDR_WIDTH +: ADDR_WIDTH] = base_q[k*ADDR_WIDTH +: ADDR_WIDTH]
                                                     + ADDR_WIDTH'(uloop_offs_i[k*REG_WIDTH +: REG_WIDTH]);
    end

    assign empty = cnt_q == '0;
    assign full  = cnt_q == CW'(FIFO_DEPTH);
    assign push  = state_q == STEP && uloop_valid_i;
    assign pop   = !empty && desc_ready_i;

    always_comb begin
        state_d        = state_q;
        uloop_clear_o  = 1'b0;
        uloop_enable_o = 1'b0;
        done_o         = 1'b0;
        case (state_q)
            IDLE:  state_d = start_i ? INIT : IDLE;
            INIT: begin
                uloop_clear_o = 1'b1;
                state_d       = STEP;
            end
            STEP: begin
                uloop_enable_o = 1'b1;
                state_d        = uloop_valid_i ? CHECK : STEP;
            end
            CHECK: state_d = last_q ? DRAIN : (!full ? STEP : CHECK);
            DRAIN: begin
                done_o  = empty;
                state_d = empty ? IDLE : DRAIN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            base_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else if (clear_i) begin
            state_q <= IDLE;
            base_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start_i) base_q <= base_i;
            if (push) begin
                wptr_q <= wptr_q + PW'(1);
                last_q <= uloop_done_i;
            end
            if (pop) rptr_q <= rptr_q + PW'(1);
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_mem_q[wptr_q] <= push_addr;
            loop_mem_q[wptr_q] <= uloop_loop_i;
            last_mem_q[wptr_q] <= uloop_done_i;
        end
    end

    assign busy_o       = state_q != IDLE;
    assign desc_valid_o = !empty;
    assign desc_addr_o  = empty ? '0 : addr_mem_q[rptr_q];
    assign desc_loop_o  = empty ? '0 : loop_mem_q[rptr_q];
    assign desc_last_o  = empty ? 1'b0 : last_mem_q[rptr_q];
endmodule

// File: tb/tb_hwpe_ctrl_uloop_seq.sv
// tb_hwpe_ctrl_uloop_seq: emulates the uloop and a consumer, scoring descriptors
// against base+offset expectations computed from the iteration list.
module tb_hwpe_ctrl_uloop_seq;
    localparam int NS = 4, NR = 4, NL = 6, RW = 32, AW = 32, FD = 2;
    localparam int LW = $clog2(NL);

    logic clk_i = 1'b0, rst_ni = 1'b0, clear_i = 1'b0, start_i = 1'b0;
    logic [NS*AW-1:0] base_i = '0;
    logic busy_o, done_o, uloop_clear_o, uloop_enable_o;
    logic uloop_valid_i = 1'b0, uloop_done_i = 1'b0;
    logic [LW-1:0] uloop_loop_i = '0;
    logic [NR*RW-1:0] uloop_offs_i = '0;
    logic desc_valid_o, desc_ready_i = 1'b0;
    logic [NS*AW-1:0] desc_addr_o;
    logic [LW-1:0] desc_loop_o;
    logic desc_last_o;

    int n_cmp = 0, n_err = 0;
    logic [NS*AW-1:0] base_v;
    logic [NR*RW-1:0] it_offs[$];
    int               it_loop[$];
    logic [NS*AW-1:0] got_addr[$];
    int               got_loop[$];
    logic             got_last[$];

    hwpe_ctrl_uloop_seq #(.NB_STREAM(NS), .NB_REG(NR), .NB_LOOPS(NL), .REG_WIDTH(RW),
                          .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i), .base_i(base_i),
        .busy_o(busy_o), .done_o(done_o), .uloop_clear_o(uloop_clear_o),
        .uloop_enable_o(uloop_enable_o), .uloop_valid_i(uloop_valid_i),
        .uloop_done_i(uloop_done_i), .uloop_loop_i(uloop_loop_i), .uloop_offs_i(uloop_offs_i),
        .desc_valid_o(desc_valid_o), .desc_ready_i(desc_ready_i), .desc_addr_o(desc_addr_o),
        .desc_loop_o(desc_loop_o), .desc_last_o(desc_last_o));

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Runs one job from start to done using it_offs/it_loop as the uloop iteration list.
    task automatic run_job(input int ready_pct, input int valid_pct, input int stall, input bit poke);
        int n = it_offs.size();
        logic [NS*AW-1:0] ea[$];
        int el[$];
        bit elast[$];
        int idx = 0, pushes = 0, pops = 0, last_pop = -10, clr_seen = 0;
        bit pushed_prev = 0, pv = 0, pr = 0, en_after = 0, finished = 0;
        logic [NS*AW-1:0] pa;
        logic [LW-1:0] pl;
        logic plast;
        got_addr.delete(); got_loop.delete(); got_last.delete();
        for (int i = 0; i < n; i++) begin
            logic [NS*AW-1:0] a;
            for (int k = 0; k < NS; k++) a[k*AW +: AW] = base_v[k*AW +: AW] + it_offs[i][k*RW +: RW];
            ea.push_back(a); el.push_back(it_loop[i]); elast.push_back(i == n - 1);
        end
        base_i = base_v; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n_cmp++;
        if ({busy_o, uloop_clear_o, uloop_enable_o} !== 3'b110) begin
            n_err++; $display("FAIL init_cycle: busy/clear/enable got %b expected 110", {busy_o, uloop_clear_o, uloop_enable_o});
        end
        tick();
        n_cmp++;
        if ({uloop_clear_o, uloop_enable_o} !== 2'b01) begin
            n_err++; $display("FAIL step_cycle: clear/enable got %b expected 01", {uloop_clear_o, uloop_enable_o});
        end
        for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
            if (uloop_clear_o) clr_seen++;
            if (pushed_prev) begin
                n_cmp++;
                if (uloop_enable_o !== 1'b0) begin n_err++; $display("FAIL enable_after_push: got %b expected 0", uloop_enable_o); end
            end
            if (pv && !pr) begin
                n_cmp++;
                if ({desc_valid_o, desc_addr_o, desc_loop_o, desc_last_o} !== {1'b1, pa, pl, plast}) begin
                    n_err++; $display("FAIL stall_stable: got %b/%h expected 1/%h", desc_valid_o, desc_addr_o, pa);
                end
            end
            if (!desc_valid_o) begin
                n_cmp++;
                if ({desc_addr_o, desc_loop_o, desc_last_o} !== '0) begin n_err++; $display("FAIL empty_zero: addr %h loop %0d last %b expected 0", desc_addr_o, desc_loop_o, desc_last_o); end
            end
            n_cmp++;
            if (done_o !== (cyc == last_pop + 1)) begin n_err++; $display("FAIL done_timing: cyc %0d got %b expected %b", cyc, done_o, cyc == last_pop + 1); end
            if (cyc == last_pop + 1) begin
                n_cmp++;
                if (busy_o !== 1'b1) begin n_err++; $display("FAIL busy_at_done: got %b expected 1", busy_o); end
            end
            if (cyc == last_pop + 2) begin
                n_cmp++;
                if (busy_o !== 1'b0) begin n_err++; $display("FAIL busy_after_done: got %b expected 0", busy_o); end
                finished = 1;
            end else begin
                if (stall > 0 && cyc < stall) desc_ready_i = 1'b0;
                else if (stall > 0 && cyc == stall) desc_ready_i = 1'b1;
                else desc_ready_i = $urandom_range(99) < ready_pct;
                if (stall > 0 && cyc == stall - 1) begin
                    n_cmp++;
                    if (pushes != FD || uloop_enable_o !== 1'b0) begin n_err++; $display("FAIL backpressure: pushes %0d enable %b expected %0d/0", pushes, uloop_enable_o, FD); end
                end
                if (stall > 0 && cyc > stall && cyc <= stall + 2 && uloop_enable_o) en_after = 1;
                if (stall > 0 && cyc == stall + 2) begin
                    n_cmp++;
                    if (!en_after) begin n_err++; $display("FAIL reenable: got 0 expected 1 within 2 cycles of pop"); end
                end
                if (desc_valid_o && desc_ready_i) begin
                    n_cmp++;
                    if (ea.size() == 0) begin
                        n_err++; $display("FAIL extra_desc: got %h expected none", desc_addr_o);
                    end else begin
                        if ({desc_addr_o, desc_loop_o, desc_last_o} !== {ea[0], LW'(el[0]), elast[0]}) begin
                            n_err++; $display("FAIL desc_pop%0d: got %h/%0d/%b expected %h/%0d/%b", pops, desc_addr_o, desc_loop_o, desc_last_o, ea[0], el[0], elast[0]);
                        end
                        if (elast[0]) last_pop = cyc;
                        void'(ea.pop_front()); void'(el.pop_front()); void'(elast.pop_front());
                    end
                    got_addr.push_back(desc_addr_o); got_loop.push_back(int'(desc_loop_o)); got_last.push_back(desc_last_o);
                    pops++;
                end
                pushed_prev = 0;
                start_i = poke && uloop_enable_o;
                if (start_i) base_i = rnd128();
                if (uloop_enable_o && idx < n && $urandom_range(99) < valid_pct) begin
                    uloop_valid_i = 1'b1; uloop_offs_i = it_offs[idx]; uloop_loop_i = LW'(it_loop[idx]);
                    uloop_done_i = idx == n - 1; idx++; pushes++; pushed_prev = 1;
                end else begin
                    uloop_valid_i = 1'b0; uloop_done_i = 1'b0; uloop_offs_i = rnd128();
                end
                pv = desc_valid_o; pr = desc_ready_i; pa = desc_addr_o; pl = desc_loop_o; plast = desc_last_o;
                tick();
            end
        end
        n_cmp++;
        if (!finished) begin n_err++; $display("FAIL job_timeout: got no done expected done within 2000 cycles"); end
        n_cmp++;
        if (clr_seen != 0) begin n_err++; $display("FAIL clear_pulses: got %0d extra expected 0", clr_seen); end
        n_cmp++;
        if (pops != n || ea.size() != 0) begin n_err++; $display("FAIL desc_count: got %0d pops expected %0d", pops, n); end
        start_i = 1'b0; uloop_valid_i = 1'b0; uloop_done_i = 1'b0; desc_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({busy_o, done_o, uloop_clear_o, uloop_enable_o, desc_valid_o, desc_last_o} !== 6'b0) begin
            n_err++; $display("FAIL reset_flags: got %b expected 000000", {busy_o, done_o, uloop_clear_o, uloop_enable_o, desc_valid_o, desc_last_o});
        end
        n_cmp++;
        if ({desc_addr_o, desc_loop_o} !== '0) begin n_err++; $display("FAIL reset_data: got %h/%0d expected 0", desc_addr_o, desc_loop_o); end
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_single();
        base_v = rnd128(); base_v[31:0] = 32'h1000;
        it_offs.delete(); it_loop.delete();
        it_offs.push_back(rnd128()); it_offs[0][31:0] = 32'h40; it_loop.push_back(0);
        run_job(100, 100, 0, 0);
        n_cmp++;
        if (got_addr.size() != 1 || got_addr[0][31:0] !== 32'h1040 || got_last[0] !== 1'b1) begin
            n_err++; $display("FAIL single_addr0: got %h expected 00001040 last 1", got_addr.size() > 0 ? got_addr[0][31:0] : 32'hx);
        end
    endtask

    task automatic test_back_pressure();
        base_v = rnd128();
        it_offs.delete(); it_loop.delete();
        for (int i = 0; i < 3; i++) begin it_offs.push_back(rnd128()); it_loop.push_back($urandom_range(NL - 1)); end
        run_job(100, 100, 8, 0);
    endtask

    task automatic test_wrap();
        base_v = rnd128(); base_v[63:32] = 32'hFFFF_FFF0;
        it_offs.delete(); it_loop.delete();
        it_offs.push_back(rnd128()); it_offs[0][63:32] = 32'h20; it_loop.push_back(3);
        run_job(100, 100, 0, 0);
        n_cmp++;
        if (got_addr.size() != 1 || got_addr[0][63:32] !== 32'h0000_0010) begin
            n_err++; $display("FAIL wrap_addr1: got %h expected 00000010", got_addr.size() > 0 ? got_addr[0][63:32] : 32'hx);
        end
        base_v = rnd128();
        it_offs.delete(); it_loop.delete();
        for (int i = 0; i < 10; i++) begin it_offs.push_back(rnd128()); it_loop.push_back($urandom_range(NL - 1)); end
        run_job(50, 70, 0, 0);
    endtask

    task automatic test_loop_tag();
        int lp[4] = '{0, 0, 1, 2};
        bit ls[4] = '{0, 0, 0, 1};
        base_v = rnd128();
        it_offs.delete(); it_loop.delete();
        for (int i = 0; i < 4; i++) begin it_offs.push_back(rnd128()); it_loop.push_back(lp[i]); end
        run_job(60, 100, 0, 0);
        n_cmp++;
        if (got_loop.size() != 4) begin n_err++; $display("FAIL tag_count: got %0d expected 4", got_loop.size()); end
        for (int i = 0; i < 4 && i < got_loop.size(); i++) begin
            n_cmp++;
            if (got_loop[i] != lp[i] || got_last[i] !== ls[i]) begin
                n_err++; $display("FAIL tag%0d: got loop %0d last %b expected %0d/%b", i, got_loop[i], got_last[i], lp[i], ls[i]);
            end
        end
    endtask

    task automatic test_clear();
        base_i = rnd128(); start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        desc_ready_i = 1'b0; uloop_valid_i = 1'b1; uloop_done_i = 1'b0; uloop_offs_i = rnd128();
        tick();
        uloop_valid_i = 1'b0;
        n_cmp++;
        if ({busy_o, desc_valid_o, uloop_enable_o} !== 3'b110) begin
            n_err++; $display("FAIL clear_setup: busy/valid/enable got %b expected 110", {busy_o, desc_valid_o, uloop_enable_o});
        end
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        n_cmp++;
        if ({busy_o, desc_valid_o, done_o, uloop_clear_o} !== 4'b0) begin
            n_err++; $display("FAIL clear_effect: busy/valid/done/uclr got %b expected 0000", {busy_o, desc_valid_o, done_o, uloop_clear_o});
        end
        tick();
        n_cmp++;
        if ({busy_o, done_o} !== 2'b0) begin n_err++; $display("FAIL clear_no_done: busy/done got %b expected 00", {busy_o, done_o}); end
        base_v = rnd128();
        it_offs.delete(); it_loop.delete();
        for (int i = 0; i < 3; i++) begin it_offs.push_back(rnd128()); it_loop.push_back($urandom_range(NL - 1)); end
        run_job(70, 80, 0, 0);
    endtask

    task automatic test_start_busy();
        base_v = rnd128();
        it_offs.delete(); it_loop.delete();
        for (int i = 0; i < 5; i++) begin it_offs.push_back(rnd128()); it_loop.push_back($urandom_range(NL - 1)); end
        run_job(80, 60, 0, 1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_pressure();
        test_wrap();
        test_loop_tag();
        test_clear();
        test_start_busy();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    task automatic test_back_to_back();
        for (int j = 0; j < 3; j++) begin
            base_v = rnd128();
            it_offs.delete(); it_loop.delete();
            for (int i = 0; i < 2 + j; i++) begin it_offs.push_back(rnd128()); it_loop.push_back($urandom_range(NL - 1)); end
            run_job(75, 90, 0, 0);
        end
    endtask
endmodule
